// File: rtl/microondas_pkg.sv
// Shared types and constants for the microwave keypad time-entry path.
package microondas_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int SEC_MAX    = 59;
  localparam int TOTAL_W    = 13;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    COMMIT,
    HOLD
  } entry_state_t;
endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for the encoder strobe/digit plus falling-edge key pulse.
module key_sync_edge
  import microondas_pkg::bcd_t;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       loadn,
  input  logic [3:0] digit_in,
  output logic       key,
  output logic [3:0] key_digit
);
  logic ld_s1, ld_s2, ld_d;
  bcd_t dg_s1, dg_s2;

  // Strobe history resets high so leaving reset never looks like a press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ld_s1 <= 1'b1;
      ld_s2 <= 1'b1;
      ld_d  <= 1'b1;
      dg_s1 <= '0;
      dg_s2 <= '0;
    end else begin
      ld_s1 <= loadn;
      ld_s2 <= ld_s1;
      ld_d  <= ld_s2;
      dg_s1 <= digit_in;
      dg_s2 <= dg_s1;
    end
  end

  assign key       = ld_d & ~ld_s2;
  assign key_digit = dg_s2;
endmodule

// File: rtl/time_entry_reg.sv
// Keypad MM:SS entry buffer with commit-to-timer handshake.
// Optional macro SEC_CLAMP_EN: clamp a seconds field above 59 to 59 at commit.
module time_entry_reg
  import microondas_pkg::bcd_t;
  import microondas_pkg::entry_state_t;
  import microondas_pkg::SEC_MAX;
  import microondas_pkg::EMPTY;
  import microondas_pkg::ENTRY;
  import microondas_pkg::COMMIT;
  import microondas_pkg::HOLD;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TOTAL_W    = 13
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [3:0]         digit_in,
  input  logic               loadn,
  input  logic               clear,
  input  logic               start,
  input  logic               time_ready,
  output logic [3:0]         min_tens,
  output logic [3:0]         min_units,
  output logic [3:0]         sec_tens,
  output logic [3:0]         sec_units,
  output logic [2:0]         digit_cnt,
  output logic               full,
  output logic               time_valid,
  output logic [TOTAL_W-1:0] total_sec
);
  entry_state_t       state;
  logic               key;
  bcd_t               key_dig;
  logic               accept;
  logic [TOTAL_W-1:0] min_val, sec_raw, sec_use, total_nxt;

  key_sync_edge u_sync (
    .clk       (clk),
    .resetn    (resetn),
    .loadn     (loadn),
    .digit_in  (digit_in),
    .key       (key),
    .key_digit (key_dig)
  );

  assign full   = (digit_cnt == 3'(NUM_DIGITS));
  assign accept = key && (key_dig <= 4'd9) && !full;

  always_comb begin
    min_val = TOTAL_W'(min_tens) * TOTAL_W'(10) + TOTAL_W'(min_units);
    sec_raw = TOTAL_W'(sec_tens) * TOTAL_W'(10) + TOTAL_W'(sec_units);
    sec_use = sec_raw;
`ifdef SEC_CLAMP_EN
    if (sec_raw > TOTAL_W'(SEC_MAX)) sec_use = TOTAL_W'(SEC_MAX);
`endif
    total_nxt = min_val * TOTAL_W'(60) + sec_use;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= EMPTY;
      min_tens   <= '0;
      min_units  <= '0;
      sec_tens   <= '0;
      sec_units  <= '0;
      digit_cnt  <= '0;
      time_valid <= 1'b0;
      total_sec  <= '0;
    end else if (clear) begin
      state      <= EMPTY;
      min_tens   <= '0;
      min_units  <= '0;
      sec_tens   <= '0;
      sec_units  <= '0;
      digit_cnt  <= '0;
      time_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY, ENTRY: begin
          // start owns the cycle: a coincident key edge is dropped even in EMPTY
          if (start) begin
            if (state == ENTRY) state <= COMMIT;
          end else if (accept) begin
            min_tens  <= min_units;
            min_units <= sec_tens;
            sec_tens  <= sec_units;
            sec_units <= key_dig;
            digit_cnt <= digit_cnt + 3'd1;
            state     <= ENTRY;
          end
        end
        COMMIT: begin
          total_sec  <= total_nxt;
          time_valid <= 1'b1;
          state      <= HOLD;
`ifdef SEC_CLAMP_EN
          if (sec_raw > TOTAL_W'(SEC_MAX)) begin
            sec_tens  <= 4'd5;
            sec_units <= 4'd9;
          end
`endif
        end
        HOLD: begin
          if (time_valid && time_ready) begin
            time_valid <= 1'b0;
            min_tens   <= '0;
            min_units  <= '0;
            sec_tens   <= '0;
            sec_units  <= '0;
            digit_cnt  <= '0;
            state      <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_time_entry_reg.sv
// Randomized + directed bench for time_entry_reg against an arithmetic entry model.
module tb_time_entry_reg;
`ifdef SEC_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  digit_in = '0;
  logic        loadn = 1'b1;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        time_ready = 1'b0;
  logic [3:0]  min_tens, min_units, sec_tens, sec_units;
  logic [2:0]  digit_cnt;
  logic        full, time_valid;
  logic [12:0] total_sec;

  int total = 0;
  int bad = 0;

  time_entry_reg dut (
    .clk        (clk),
    .resetn     (resetn),
    .digit_in   (digit_in),
    .loadn      (loadn),
    .clear      (clear),
    .start      (start),
    .time_ready (time_ready),
    .min_tens   (min_tens),
    .min_units  (min_units),
    .sec_tens   (sec_tens),
    .sec_units  (sec_units),
    .digit_cnt  (digit_cnt),
    .full       (full),
    .time_valid (time_valid),
    .total_sec  (total_sec)
  );

  always #5 clk = ~clk;

  // Model: the buffer is a decimal number MMSS; entering a digit is buf*10+d mod 10000.
  int buf_v = 0, cnt_m = 0, total_m = 0;
  bit valid_m = 0, commit_m = 0;
  bit h1 = 1, h2 = 1, h3 = 1;
  int g1 = 0, g2 = 0;

  always @(posedge clk or negedge resetn) begin
    bit k;
    int kd, s;
    if (!resetn) begin
      buf_v = 0; cnt_m = 0; total_m = 0; valid_m = 0; commit_m = 0;
      h1 = 1; h2 = 1; h3 = 1; g1 = 0; g2 = 0;
    end else begin
      // a press is seen two samples after loadn was first sampled low
      k  = !h2 && h3;
      kd = g2;
      if (clear) begin
        buf_v = 0; cnt_m = 0; valid_m = 0; commit_m = 0;
      end else if (commit_m) begin
        s = buf_v % 100;
        if (CLAMP && s > 59) begin
          buf_v = buf_v - s + 59;
          s = 59;
        end
        total_m  = (buf_v / 100) * 60 + s;
        valid_m  = 1;
        commit_m = 0;
      end else if (valid_m) begin
        if (time_ready) begin
          valid_m = 0; buf_v = 0; cnt_m = 0;
        end
      end else if (start) begin
        if (cnt_m > 0) commit_m = 1;
      end else if (k && kd <= 9 && cnt_m < 4) begin
        buf_v = (buf_v * 10 + kd) % 10000;
        cnt_m++;
      end
      h3 = h2; h2 = h1; h1 = loadn;
      g2 = g1; g1 = int'(digit_in);
    end
  end

  always @(negedge clk) begin
    logic [33:0] act, expv;
    if (resetn) begin
      act  = {min_tens, min_units, sec_tens, sec_units, digit_cnt, full, time_valid, total_sec};
      expv = {4'(buf_v / 1000), 4'((buf_v / 100) % 10), 4'((buf_v / 10) % 10), 4'(buf_v % 10),
              3'(cnt_m), (cnt_m == 4), valid_m, 13'(total_m)};
      total++;
      if (act !== expv) begin
        bad++;
        $display("FAIL cycle_model t=%0t got=%h want=%h", $time, act, expv);
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, expv);
    end
  endtask

  task automatic press(input int d, input int hold, input int gap);
    digit_in = 4'(d);
    loadn = 1'b0;
    repeat (hold) @(negedge clk);
    loadn = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic int disp();
    return int'({min_tens, min_units, sec_tens, sec_units});
  endfunction

  initial begin
    int r;
    repeat (3) @(negedge clk);
    check("reset_disp", disp(), 0);
    check("reset_cnt", int'(digit_cnt), 0);
    check("reset_valid_total", int'({time_valid, total_sec}), 0);
    resetn = 1'b1;
    @(negedge clk);

    press(1, 10, 10); press(2, 10, 10); press(3, 10, 10); press(0, 10, 10);
    check("disp_1230", disp(), 16'h1230);
    check("cnt_full", int'({digit_cnt, full}), {3'd4, 1'b1});
    press(7, 10, 10);
    check("fifth_key_ignored", disp(), 16'h1230);
    pulse_start();
    repeat (2) @(negedge clk);
    check("commit_valid", int'(time_valid), 1);
    check("commit_750", int'(total_sec), 750);
    repeat (20) @(negedge clk);
    check("hold_stable", int'({time_valid, total_sec}), {1'b1, 13'd750});
    time_ready = 1'b1;
    @(negedge clk);
    time_ready = 1'b0;
    check("handshake_empty", int'({disp(), 3'(digit_cnt), time_valid}), 0);

    press(12, 10, 10);
    check("non_bcd_dropped", int'(digit_cnt), 0);
    pulse_start();
    repeat (3) @(negedge clk);
    check("start_in_empty", int'(time_valid), 0);

    press(1, 10, 10); press(9, 10, 10); press(9, 10, 10);
    pulse_start();
    repeat (3) @(negedge clk);
    check("commit_1_99", int'(total_sec), CLAMP ? 119 : 159);
    check("disp_1_99", disp(), CLAMP ? 16'h0159 : 16'h0199);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_in_hold", int'(time_valid), 0);

    press(5, 10, 10);
    check("one_digit", int'(digit_cnt), 1);
    digit_in = 4'd6;
    loadn = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_with_key", int'({disp(), 3'(digit_cnt)}), 0);
    repeat (7) @(negedge clk);
    loadn = 1'b1;
    repeat (10) @(negedge clk);
    check("no_late_key", int'(digit_cnt), 0);

    press(4, 10, 10); press(2, 10, 10);
    check("two_digits", int'(digit_cnt), 2);
    #2 resetn = 1'b0;
    #1 check("async_reset", int'({disp(), 3'(digit_cnt), time_valid, total_sec}), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    check("no_spurious_key", int'(digit_cnt), 0);

    repeat (300) begin
      r = $urandom_range(0, 9);
      if (r <= 5) press($urandom_range(0, 11), $urandom_range(2, 8), $urandom_range(2, 6));
      else if (r == 6) pulse_start();
      else if (r == 7) begin
        time_ready = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        time_ready = 1'b0;
      end else if (r == 8) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
      end else repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
